// File: rtl/global_ram_unloader.sv
// global_ram_unloader: streams size words from global BRAM at base_addr out over valid/ready with last.
// Ports: clk/reset (sync, active-high); start/base_addr/size launch a transfer;
// re_global/rd_addr_global/data_rd_global form the 1-cycle-latency BRAM read port;
// dout/dout_valid/dout_ready/dout_last form the output stream; busy/done report status.
// Build option: define GLOBAL_UNLOADER_BYTE_SWAP_EN to byte-reverse each word into the FIFO.
module global_ram_unloader #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] size,
  output logic              re_global,
  output logic [ADDR_W-1:0] rd_addr_global,
  input  logic [DATA_W-1:0] data_rd_global,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] ptr, iss_rem, out_rem;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [DATA_W-1:0] wdata;
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic [PW+1:0] credit;
  logic infl, issue, pop;
`ifdef GLOBAL_UNLOADER_BYTE_SWAP_EN
  for (genvar b = 0; b < DATA_W / 8; b++) begin : g_swap
    assign wdata[8*b +: 8] = data_rd_global[DATA_W-8-8*b +: 8];
  end
`else
  assign wdata = data_rd_global;
`endif
  // Credit uses the pre-pop count so a full FIFO never accepts an issue, even while popping.
  assign credit = {1'b0, cnt} + {{(PW+1){1'b0}}, infl};
  assign issue = state == READ && credit < (PW+2)'(FIFO_DEPTH);
  assign dout_valid = cnt != '0;
  assign pop = dout_valid && dout_ready;
  assign dout = dout_valid ? mem[rp] : '0;
  assign dout_last = dout_valid && out_rem == ADDR_W'(1);
  assign re_global = issue;
  assign rd_addr_global = ptr;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start ? (size == '0 ? DONE : READ) : IDLE;
      READ:  nxt = issue && iss_rem == ADDR_W'(1) ? DRAIN : READ;
      DRAIN: nxt = pop && out_rem == ADDR_W'(1) ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      iss_rem <= '0;
      out_rem <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      infl <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        ptr <= base_addr;
        iss_rem <= size;
        out_rem <= size;
      end
      if (issue) begin
        ptr <= ptr + ADDR_W'(1);
        iss_rem <= iss_rem - ADDR_W'(1);
      end
      infl <= issue;
      if (infl) wp <= wp + PW'(1);
      if (pop) begin
        rp <= rp + PW'(1);
        out_rem <= out_rem - ADDR_W'(1);
      end
      cnt <= cnt + (PW+1)'(infl) - (PW+1)'(pop);
    end
  end
  // Storage needs no reset: occupancy is tracked by cnt and dout is gated by dout_valid.
  always_ff @(posedge clk)
    if (infl) mem[wp] <= wdata;
endmodule

// File: tb/tb_global_ram_unloader.sv
// tb_global_ram_unloader: randomized scoreboard bench for global_ram_unloader.
module tb_global_ram_unloader;
  logic clk = 0, reset = 1, start = 0;
  logic [31:0] base_addr = '0, size = '0;
  logic re_global;
  logic [31:0] rd_addr_global;
  logic [127:0] data_rd_global = '0, dout;
  logic dout_valid, dout_ready = 1, dout_last, busy, done;
  int tests = 0, fails = 0, rmode = 0, ph = 0, occ = 0;
  logic [127:0] exp_d[$];
  logic exp_l[$];
  logic [31:0] exp_a[$];
  logic st_prev = 0, st_l = 0;
  logic [127:0] st_d = '0;

  always #5 clk = ~clk;

  global_ram_unloader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .size(size),
    .re_global(re_global), .rd_addr_global(rd_addr_global), .data_rd_global(data_rd_global),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .busy(busy), .done(done)
  );

  function automatic logic [127:0] bram(input logic [31:0] a);
    if (a == 32'h100) return 128'h000102030405060708090A0B0C0D0E0F;
    return {32'hA5A5_0000 + a, a ^ 32'h5A5A_5A5A, ~a, a * 32'd7};
  endfunction

  function automatic logic [127:0] model(input logic [31:0] a);
    logic [127:0] w, r;
    w = bram(a);
    r = w;
`ifdef GLOBAL_UNLOADER_BYTE_SWAP_EN
    for (int i = 0; i < 16; i++) r[8*i +: 8] = w[120-8*i +: 8];
`endif
    return r;
  endfunction

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(posedge clk) data_rd_global <= re_global ? bram(rd_addr_global) : {$urandom, $urandom, $urandom, $urandom};

  initial forever begin
    @(posedge clk);
    #1;
    dout_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (ph % 4 == 0 || ph % 4 == 3) : 1'($urandom_range(0, 1));
    ph++;
  end

  always @(negedge clk) if (!reset) begin
    if (st_prev) begin
      chk("stall_dout", dout, st_d);
      chk("stall_valid_last", {dout_valid, dout_last}, {1'b1, st_l});
    end
    st_prev = dout_valid && !dout_ready;
    st_d = dout;
    st_l = dout_last;
    if (re_global) begin
      chk("credit", occ < 4, 1);
      if (exp_a.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_read: got addr %h expected no read", rd_addr_global);
      end else chk("rd_addr", rd_addr_global, exp_a.pop_front());
      occ++;
    end
    if (dout_valid && dout_ready) begin
      if (exp_d.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_word: got %h expected no word", dout);
      end else begin
        chk("dout", dout, exp_d.pop_front());
        chk("dout_last", dout_last, exp_l.pop_front());
      end
      occ--;
    end
  end

  task automatic xfer(input logic [31:0] b, input int n, input int mode);
    bit found;
    int k;
    rmode = mode;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(b + i);
      exp_d.push_back(model(b + i));
      exp_l.push_back(i == n - 1);
    end
    start = 1;
    base_addr = b;
    size = n;
    @(posedge clk);
    #1;
    start = 0;
    base_addr = $urandom;
    size = $urandom;
    found = 0;
    k = 0;
    for (int j = 1; j <= 3000 && !found; j++) begin
      @(negedge clk);
      if (j == 1) chk("busy_rise", busy, 1);
      if (done) begin
        found = 1;
        k = j;
      end
    end
    chk("done_seen", found, 1);
    if (mode == 0) chk("done_cycle", k, n == 0 ? 1 : n + 3);
    chk("words_left", exp_d.size(), 0);
    chk("reads_left", exp_a.size(), 0);
    @(negedge clk);
    chk("busy_fall", {busy, done}, 2'b00);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_re", re_global, 0);
    chk("rst_addr", rd_addr_global, 0);
    chk("rst_dout", dout, 0);
    chk("rst_flags", {dout_valid, dout_last, busy, done}, 4'b0000);
    @(posedge clk);
    #1;
    reset = 0;
    xfer(32'h10, 8, 0);
    xfer(32'h10, 8, 1);
    xfer(32'h55, 0, 0);
    xfer(32'hFFFF_FFFE, 4, 0);
    xfer(32'h100, 1, 0);
    rmode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      exp_a.push_back(32'h300 + i);
      exp_d.push_back(model(32'h300 + i));
      exp_l.push_back(i == 15);
    end
    start = 1;
    base_addr = 32'h300;
    size = 16;
    @(posedge clk);
    #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    exp_a.delete();
    exp_d.delete();
    exp_l.delete();
    occ = 0;
    st_prev = 0;
    @(negedge clk);
    chk("abort_dout", dout, 0);
    chk("abort_flags", {re_global, dout_valid, dout_last, busy, done}, 5'b00000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_quiet", {done, dout_valid, busy}, 3'b000);
    end
    @(posedge clk);
    #1;
    xfer(32'h200, 2, 0);
    for (int t = 0; t < 20; t++) xfer($urandom, $urandom_range(1, 40), $urandom_range(0, 2));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
